// File: rtl/l2_mem_ctrl.sv
// l2_mem_ctrl: line-granular memory responder below l2_cache.
// In-order request FIFO, fixed-latency access FSM (IDLE/ACCESS/RESPOND) and
// a backing store of whole cache lines that is cleared by reset.
// Optional macro MEM_LATENCY_JITTER_EN adds 0-7 cycles of LFSR-driven
// latency per request.
module l2_mem_ctrl #(
  parameter int unsigned MEM_LINES       = 256,
  parameter int unsigned LATENCY         = 4,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned CACHE_LINE_BITS = 512
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mem_req_valid,
  input  logic                       mem_req_we,
  input  logic [ADDR_WIDTH-1:0]      mem_req_addr,
  input  logic [CACHE_LINE_BITS-1:0] mem_req_wdata,
  output logic                       mem_resp_valid,
  output logic [CACHE_LINE_BITS-1:0] mem_resp_rdata,
  output logic                       mem_ready,
  output logic [31:0]                rd_count,
  output logic [31:0]                wr_count,
  output logic [31:0]                err_count
);

  localparam int unsigned OFFSET_BITS = $clog2(CACHE_LINE_BITS / 8);
  localparam int unsigned IDX_BITS    = $clog2(MEM_LINES);
  localparam int unsigned PTR_BITS    = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_BITS    = $clog2(LATENCY + 8);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESPOND
  } state_t;

  // Request FIFO storage and pointers
  logic                       r_q_we    [QUEUE_DEPTH];
  logic                       r_q_oor   [QUEUE_DEPTH];
  logic [IDX_BITS-1:0]        r_q_idx   [QUEUE_DEPTH];
  logic [CACHE_LINE_BITS-1:0] r_q_wdata [QUEUE_DEPTH];
  logic [PTR_BITS-1:0]        r_wr_ptr;
  logic [PTR_BITS-1:0]        r_rd_ptr;
  logic [PTR_BITS:0]          r_count;
  logic                       r_live;

  // Working register and FSM state
  state_t                     r_state;
  logic [CNT_BITS-1:0]        r_cnt;
  logic                       r_we;
  logic                       r_oor;
  logic [IDX_BITS-1:0]        r_idx;
  logic [CACHE_LINE_BITS-1:0] r_wdata;
  logic                       r_resp_valid;
  logic [CACHE_LINE_BITS-1:0] r_rdata;
  logic [31:0]                r_rd_count;
  logic [31:0]                r_wr_count;
  logic [31:0]                r_err_count;
  logic [CACHE_LINE_BITS-1:0] r_mem [MEM_LINES];

  logic                       w_full;
  logic                       w_empty;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_acc_done;
  logic [IDX_BITS-1:0]        w_in_idx;
  logic                       w_in_oor;
  logic [CNT_BITS-1:0]        w_load_cnt;
  logic                       w_unused_addr_lo;

  assign w_in_idx         = mem_req_addr[OFFSET_BITS +: IDX_BITS];
  assign w_in_oor         = |mem_req_addr[ADDR_WIDTH-1:OFFSET_BITS+IDX_BITS];
  assign w_unused_addr_lo = ^mem_req_addr[OFFSET_BITS-1:0];

  assign w_full     = (r_count == (PTR_BITS+1)'(QUEUE_DEPTH));
  assign w_empty    = (r_count == '0);
  assign mem_ready  = r_live && !w_full;
  assign w_push     = mem_req_valid && mem_ready;
  assign w_acc_done = (r_state == ST_ACCESS) && (r_cnt == '0);
  // Pop only from registered occupancy: a same-edge push is never bypassed
  assign w_pop      = !w_empty && ((r_state == ST_IDLE) || (r_state == ST_RESPOND) ||
                                   (w_acc_done && r_we));

`ifdef MEM_LATENCY_JITTER_EN
  logic [7:0] r_lfsr;

  // Free-running x^8+x^6+x^5+x^4+1 LFSR supplying per-request extra latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_load_cnt = CNT_BITS'(LATENCY - 2) + CNT_BITS'(r_lfsr[2:0]);
`else
  assign w_load_cnt = CNT_BITS'(LATENCY - 2);
`endif

  // FIFO entry storage (contents are don't-care while empty)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_we[r_wr_ptr]    <= mem_req_we;
      r_q_oor[r_wr_ptr]   <= w_in_oor;
      r_q_idx[r_wr_ptr]   <= w_in_idx;
      r_q_wdata[r_wr_ptr] <= mem_req_wdata;
    end
  end

  // FIFO pointers, occupancy and post-reset ready enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_live   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Access FSM, backing store and statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_oor        <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_rd_count   <= '0;
      r_wr_count   <= '0;
      r_err_count  <= '0;
      for (int unsigned i = 0; i < MEM_LINES; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        ST_ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            if (r_oor) r_err_count <= r_err_count + 32'd1;
            if (!r_we) begin
              r_rdata      <= r_oor ? '0 : r_mem[r_idx];
              r_resp_valid <= 1'b1;
              r_state      <= ST_RESPOND;
            end else begin
              if (!r_oor) begin
                r_mem[r_idx] <= r_wdata;
                r_wr_count   <= r_wr_count + 32'd1;
              end
              r_state <= ST_IDLE;
            end
          end
        end
        ST_RESPOND: begin
          r_rd_count <= r_rd_count + 32'd1;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      // Every pop (from IDLE, after a write commit, or after RESPOND) loads
      // the working register here, overriding the IDLE fallback above.
      if (w_pop) begin
        r_we    <= r_q_we[r_rd_ptr];
        r_oor   <= r_q_oor[r_rd_ptr];
        r_idx   <= r_q_idx[r_rd_ptr];
        r_wdata <= r_q_wdata[r_rd_ptr];
        r_cnt   <= w_load_cnt;
        r_state <= ST_ACCESS;
      end
    end
  end

  assign mem_resp_valid = r_resp_valid;
  assign mem_resp_rdata = r_rdata;
  assign rd_count       = r_rd_count;
  assign wr_count       = r_wr_count;
  assign err_count      = r_err_count;

endmodule

// File: tb/tb_l2_mem_ctrl.sv
// tb_l2_mem_ctrl: scoreboard bench for l2_mem_ctrl. Expected read data comes
// from a line model updated at request acceptance; responses are popped and
// compared as the DUT produces them.
module tb_l2_mem_ctrl;

  localparam int unsigned LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_req_valid = 1'b0;
  logic         mem_req_we = 1'b0;
  logic [31:0]  mem_req_addr = '0;
  logic [511:0] mem_req_wdata = '0;
  logic         mem_resp_valid;
  logic [511:0] mem_resp_rdata;
  logic         mem_ready;
  logic [31:0]  rd_count;
  logic [31:0]  wr_count;
  logic [31:0]  err_count;

  l2_mem_ctrl #(
    .MEM_LINES       (256),
    .LATENCY         (LAT),
    .QUEUE_DEPTH     (4),
    .ADDR_WIDTH      (32),
    .CACHE_LINE_BITS (512)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .mem_ready      (mem_ready),
    .rd_count       (rd_count),
    .wr_count       (wr_count),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    int           acc_edge;
    bit           timed;
  } exp_t;

  exp_t         sb[$];
  logic [511:0] mdl[int];
  int           n_checks = 0;
  int           n_pass = 0;
  int           edge_cnt = 0;
  int           exp_rd = 0;
  int           exp_wr = 0;
  int           exp_err = 0;

  always @(posedge clk) edge_cnt++;

  task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
  endtask

  // Response monitor: pop scoreboard, compare data and (unloaded) latency
  always @(negedge clk) begin
    if (rst_n && mem_resp_valid) begin
      if (sb.size() == 0) begin
        check_eq("spurious_resp", mem_resp_valid, 1'b0);
      end else begin
        exp_t e;
        int   lat;
        e = sb.pop_front();
        check_eq("rdata", mem_resp_rdata, e.data);
        if (e.timed) begin
          lat = edge_cnt - e.acc_edge;
`ifdef MEM_LATENCY_JITTER_EN
          check_eq("latency_range", (lat >= 4 && lat <= 11), 1'b1);
`else
          check_eq("latency", lat, LAT);
`endif
        end
      end
    end
  end

  // Drive one request from a negedge until accepted; update model/scoreboard
  task automatic issue(input bit we, input logic [31:0] addr, input logic [511:0] data,
                       input bit timed, output bit stalled);
    int guard;
    int idx;
    bit oor;
    exp_t e;
    stalled       = 1'b0;
    mem_req_valid = 1'b1;
    mem_req_we    = we;
    mem_req_addr  = addr;
    mem_req_wdata = data;
    guard = 0;
    while (!mem_ready && guard < 200) begin
      stalled = 1'b1;
      @(negedge clk);
      guard++;
    end
    if (!mem_ready) begin
      check_eq("accept_timeout", mem_ready, 1'b1);
      mem_req_valid = 1'b0;
      return;
    end
    idx = int'(addr[13:6]);
    oor = |addr[31:14];
    if (oor) exp_err++;
    if (we) begin
      if (!oor) begin
        mdl[idx] = data;
        exp_wr++;
      end
    end else begin
      exp_rd++;
      e.data     = (oor || !mdl.exists(idx)) ? '0 : mdl[idx];
      e.acc_edge = edge_cnt + 1;
      e.timed    = timed;
      sb.push_back(e);
    end
    @(negedge clk);
    mem_req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) check_eq("drain_timeout", sb.size(), 0);
    repeat (LAT + 12) @(negedge clk);
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, "_rd_count"}, rd_count, exp_rd);
    check_eq({tag, "_wr_count"}, wr_count, exp_wr);
    check_eq({tag, "_err_count"}, err_count, exp_err);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_req_valid = 1'b0;
    sb.delete();
    mdl.delete();
    exp_rd = 0;
    exp_wr = 0;
    exp_err = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", mem_ready, 1'b0);
    check_eq("rst_resp_valid", mem_resp_valid, 1'b0);
    check_eq("rst_rdata", mem_resp_rdata, '0);
    check_counters("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", mem_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           st;
    bit           any_stall;
    logic [511:0] pat;
    logic [511:0] d;

    do_reset();

    // Unloaded read of a never-written line
    issue(1'b0, 32'h0000_0040, '0, 1'b1, st);
    drain();
    check_counters("read0");

    // Writeback followed immediately by a fill of the same line
    pat = {16{32'hDEAD_BEEF}};
    issue(1'b1, 32'h0000_0080, pat, 1'b0, st);
    issue(1'b0, 32'h0000_0080, '0, 1'b0, st);
    drain();
    check_counters("wr_rd");

    // Distinct lines, then 6 held reads to exercise full-FIFO back-pressure
    for (int i = 0; i < 6; i++) begin
      d = {16{32'hC0DE_0000 + 32'(i)}};
      issue(1'b1, 32'h0000_1000 + 32'(i * 64), d, 1'b0, st);
    end
    any_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, 32'h0000_1000 + 32'(i * 64), '0, 1'b0, st);
      any_stall = any_stall | st;
    end
    check_eq("ready_backpressure", any_stall, 1'b1);
    drain();
    check_counters("burst");

    // Out-of-range read and write; the write must not alias onto line 0
    issue(1'b0, 32'h0001_0000, '0, 1'b1, st);
    issue(1'b1, 32'h0001_0000, {16{32'h1234_5678}}, 1'b0, st);
    issue(1'b0, 32'h0000_0000, '0, 1'b0, st);
    drain();
    check_counters("oor");

    // Reset one cycle after accepting a read of a written line
    issue(1'b1, 32'h0000_0100, {16{32'hA5A5_5A5A}}, 1'b0, st);
    drain();
    issue(1'b0, 32'h0000_0100, '0, 1'b0, st);
    do_reset();
    repeat (LAT + 4) @(negedge clk);
    check_eq("no_resp_after_rst", mem_resp_valid, 1'b0);
    check_counters("post_rst");
    issue(1'b0, 32'h0000_0100, '0, 1'b1, st);
    drain();
    check_counters("rd_after_rst");

    // Sixteen unloaded reads of lines with distinct contents
    for (int i = 0; i < 16; i++) begin
      d = {16{32'hF00D_0000 + 32'(i * 3)}};
      issue(1'b1, 32'h0000_2000 + 32'(i * 64), d, 1'b0, st);
    end
    drain();
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, 32'h0000_2000 + 32'(i * 64), '0, 1'b1, st);
      drain();
    end
    check_counters("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
